// File: rtl/clk_enable_gen_pkg.sv
`default_nettype none
// ============================================================================
// clk_gen_pkg : shared types for the clock-enable generator
// Rev 1.0
// ============================================================================
package clk_gen_pkg;

  // Widest divide/phase a channel can hold; narrower config buses are zero-extended.
  localparam int CFG_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
    logic             en;
  } chan_cfg_t;

  // Counter preset on commit: min(phase, N-1), or 0 when the divider is bypassed.
  function automatic logic [CFG_W-1:0] start_count(chan_cfg_t c);
    if (!c.en || c.div < CFG_W'(2)) begin
      return '0;
    end
    return (c.phase < c.div) ? c.phase : c.div - CFG_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_enable_gen_if.sv
`default_nettype none
// ============================================================================
// clk_enable_gen_if : shadow-register write and commit bus
// Rev 1.0
// ============================================================================
interface clk_enable_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_en;
  logic             apply;

  modport master (
    output cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en, apply,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en, apply,
    output cfg_ready
  );

endinterface
`default_nettype wire

// File: rtl/clk_enable_gen_channel.sv
`default_nettype none
// ============================================================================
// clk_div_channel : one divide-by-N enable / square-wave channel
// Rev 1.0
// ============================================================================
module clk_div_channel
  import clk_gen_pkg::*;
(
  input  logic      refclk,
  input  logic      reset_n,
  input  logic      load_i,
  input  logic      run_i,
  input  chan_cfg_t cfg_i,
  output logic      ce_o,
  output logic      clk_lvl_o
);

  logic [CFG_W-1:0] div_q;
  logic             en_q;
  logic [CFG_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic             lvl_q, lvl_d;
  logic [CFG_W-1:0] last;
  logic             bypass;

  assign last   = div_q - CFG_W'(1);
  assign bypass = div_q < CFG_W'(2);

  always_comb begin
    cnt_d = cnt_q;
    ce_d  = 1'b0;
    lvl_d = 1'b0;
    if (load_i) begin
      cnt_d = start_count(cfg_i);
    end else if (run_i && en_q) begin
      if (bypass) begin
        ce_d  = 1'b1;
        cnt_d = '0;
      end else begin
        ce_d  = (cnt_q == last);
        lvl_d = (cnt_q < (div_q >> 1));
        cnt_d = (cnt_q == last) ? '0 : cnt_q + CFG_W'(1);
      end
    end
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      en_q  <= 1'b0;
      cnt_q <= '0;
      ce_q  <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      if (load_i) begin
        div_q <= cfg_i.div;
        en_q  <= cfg_i.en;
      end
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
      lvl_q <= lvl_d;
    end
  end

  assign ce_o      = ce_q;
  assign clk_lvl_o = lvl_q;

endmodule
`default_nettype wire

// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// clk_enable_gen : NUM_CH phase-aligned clock enables with shadowed config
// Rev 1.0
// ============================================================================
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              reset_n,
  clk_enable_gen_if.slave   cfg_if,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] clk_lvl_o,
  output logic              locked_o
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             cfg_ready_q;
  logic             locked_q;
  chan_cfg_t        shadow_q [NUM_CH];
  chan_cfg_t        wr_cfg;
  logic [DIV_W-1:0] wr_div;
  logic [DIV_W-1:0] wr_phase;
  logic             wr_fire;
  logic             load;
  logic             run;

  assign wr_div   = cfg_if.cfg_div;
  assign wr_phase = cfg_if.cfg_phase;
  assign wr_fire  = cfg_if.cfg_valid && cfg_ready_q;

  always_comb begin
    wr_cfg       = '0;
    wr_cfg.div   = CFG_W'(wr_div);
    wr_cfg.phase = CFG_W'(wr_phase);
    wr_cfg.en    = cfg_if.cfg_en;
  end

  // Out-of-range channel numbers match no slot, so the write is silently dropped.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(cfg_if.cfg_ch) == i) begin
          shadow_q[i] <= wr_cfg;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (cfg_if.apply) state_d = ALIGN;
      end
      ALIGN: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (cfg_if.apply) begin
          state_d = ALIGN;
        end else if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
          state_d = LOCKED;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      LOCKED: begin
        if (cfg_if.apply) state_d = ALIGN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      cfg_ready_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cfg_ready_q <= (state_d != ALIGN);
      locked_q    <= (state_d == LOCKED);
    end
  end

  assign cfg_if.cfg_ready = cfg_ready_q;
  assign locked_o         = locked_q;

  // The ALIGN cycle commits every shadow at once, which is what keeps channels phase-aligned.
  assign load = (state_q == ALIGN);
  assign run  = (state_q == SETTLE) || (state_q == LOCKED);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel u_chan (
      .refclk    (refclk),
      .reset_n   (reset_n),
      .load_i    (load),
      .run_i     (run),
      .cfg_i     (shadow_q[g]),
      .ce_o      (ce_o[g]),
      .clk_lvl_o (clk_lvl_o[g])
    );
  end

endmodule
`default_nettype wire
